tdm_demux4: RTL

Four-channel time-division demultiplexer: the receive end of a serial link whose transmitter steps a 4-to-1 mux through slots 0..3 on selects S1,S0. It aligns to a frame sync, de-interleaves one bit per slot into four per-channel shift registers, and presents all four assembled WIDTH-bit words together on a valid/ready output with overflow detection. It sits between the serial link and the downstream word consumers.

---
 rtl/tdm_demux4.sv | 107 ++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Four-channel TDM receive demultiplexer: aligns to frame sync, de-interleaves one
// bit per slot into per-channel shift registers and presents the four words on valid/ready.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             en,
    input  logic             sync,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err,
    output logic             overflow
);

    localparam int FW = $clog2(WIDTH);
    localparam logic [FW-1:0] LAST_FRAME = FW'(WIDTH - 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t           state_reg;
    logic [FW-1:0]    frame_reg;
    logic [WIDTH-1:0] shr_reg   [4];
    logic [WIDTH-1:0] shr_shift [4];
    logic [WIDTH-1:0] word_bits [4];
    logic [WIDTH-1:0] first_bit;
    logic             realign;
    logic             capture;
    logic             word_done;
    logic             handshake;

    // word_bits holds each channel's contents including a bit captured on this edge,
    // so channel 3 completes with zero latency.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign shr_shift[gi] = {shr_reg[gi][WIDTH-2:0], sin};
            assign word_bits[gi] = (slot == 2'(gi)) ? shr_shift[gi] : shr_reg[gi];
        end
    endgenerate

    assign first_bit = {{(WIDTH-1){1'b0}}, sin};
    assign handshake = out_valid && out_ready;
    assign realign   = en && sync && ((state_reg == HUNT) || (slot != 2'd0));
    assign capture   = en && (state_reg == LOCK) && !realign;
    assign word_done = capture && (slot == 2'd3) && (frame_reg == LAST_FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            frame_reg <= '0;
            for (int c = 0; c < 4; c++) begin
                shr_reg[c] <= '0;
            end
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            slot      <= 2'd0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync_err <= 1'b0;

            // A sync in HUNT or a misaligned sync in LOCK both restart at slot 0, frame 0.
            if (realign) begin
                for (int c = 0; c < 4; c++) begin
                    shr_reg[c] <= (c == 0) ? first_bit : '0;
                end
                slot      <= 2'd1;
                frame_reg <= '0;
                state_reg <= LOCK;
                locked    <= 1'b1;
                sync_err  <= (state_reg == LOCK);
            end else if (capture) begin
                shr_reg[slot] <= shr_shift[slot];
                slot          <= slot + 2'd1;
                if (slot == 2'd3) begin
                    frame_reg <= (frame_reg == LAST_FRAME) ? '0 : frame_reg + FW'(1);
                end
            end

            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out0      <= word_bits[0];
                    out1      <= word_bits[1];
                    out2      <= word_bits[2];
                    out3      <= word_bits[3];
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
